// File: rtl/sorted_record_packer_if.sv
// Record-stream / word-FIFO bundle between the merge-sorter tree, the
// packer and the write-back consumer.
//   master : tree/consumer side. Drives DIN, DINEN, FLUSH and OUT_DEQ.
//            Observes IN_FULL, DOT, DOTEN, WORD_CNT, ORDER_ERR and OVERFLOW.
//   slave  : the packer. Takes the opposite directions.
interface sorted_record_packer_if #(
    parameter int P_LOG = 3,
    parameter int DATW  = 64
);
    logic [DATW-1:0]          DIN;
    logic                     DINEN;
    logic                     FLUSH;
    logic                     OUT_DEQ;
    logic                     IN_FULL;
    logic [(DATW<<P_LOG)-1:0] DOT;
    logic                     DOTEN;
    logic [31:0]              WORD_CNT;
    logic                     ORDER_ERR;
    logic                     OVERFLOW;

    modport master (
        output DIN, DINEN, FLUSH, OUT_DEQ,
        input  IN_FULL, DOT, DOTEN, WORD_CNT, ORDER_ERR, OVERFLOW
    );

    modport slave (
        input  DIN, DINEN, FLUSH, OUT_DEQ,
        output IN_FULL, DOT, DOTEN, WORD_CNT, ORDER_ERR, OVERFLOW
    );
endinterface

// File: rtl/sorted_record_packer.sv
// Packs the sorted single-record stream from the merge-sorter tree into words
// of 2^P_LOG records and queues them in a 2^FIFO_LOG-deep word FIFO.
// Slot 0 of a word is at the LSB end.
//   CLK, RST   : clock and synchronous active-high reset.
//   bus.slave  : DIN/DINEN record input, FLUSH for a partial word,
//                OUT_DEQ pops the head word, DOT/DOTEN show the head word,
//                IN_FULL stalls the tree, WORD_CNT counts accepted words,
//                ORDER_ERR and OVERFLOW are sticky error flags.
module sorted_record_packer #(
    parameter int P_LOG    = 3,
    parameter int DATW     = 64,
    parameter int KEYW     = 32,
    parameter int FIFO_LOG = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    sorted_record_packer_if.slave bus
);
    localparam int NREC  = 1 << P_LOG;
    localparam int WORDW = DATW * NREC;
    localparam int DEPTH = 1 << FIFO_LOG;

    localparam logic [P_LOG-1:0]  LAST_SLOT = P_LOG'(NREC - 1);
    localparam logic [FIFO_LOG:0] CNT_FULL  = (FIFO_LOG+1)'(DEPTH);
    localparam logic [FIFO_LOG:0] CNT_HIGH  = (FIFO_LOG+1)'(DEPTH - 1);

    logic [WORDW-1:0]    asm_q;
    logic [WORDW-1:0]    word_next;
    logic [P_LOG-1:0]    fill_q;
    logic [WORDW-1:0]    mem [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr_q;
    logic [FIFO_LOG-1:0] rd_ptr_q;
    logic [FIFO_LOG:0]   count_q;
    logic [31:0]         word_cnt_q;
    logic [KEYW-1:0]     prev_key_q;
    logic                seen_q;
    logic                order_err_q;
    logic                overflow_q;
    logic                push;
    logic                pop;
    logic                accept;
    logic                drop;

    // Slots below fill come from the assembly register, the current record
    // lands in slot fill, and everything above is padded with all-ones so
    // padding sorts after every real key. The assembly register is never
    // cleared; the fill-based mask hides stale contents.
    always_comb begin
        word_next = '1;
        for (int k = 0; k < NREC; k++) begin
            if (P_LOG'(k) < fill_q)
                word_next[k*DATW +: DATW] = asm_q[k*DATW +: DATW];
            else if (P_LOG'(k) == fill_q && bus.DINEN)
                word_next[k*DATW +: DATW] = bus.DIN;
        end
    end

    assign push   = (bus.DINEN && fill_q == LAST_SLOT)
                 || (bus.FLUSH && (fill_q != '0 || bus.DINEN));
    assign pop    = bus.OUT_DEQ && count_q != '0;
    // A full FIFO still accepts when the head is popped in the same cycle.
    assign accept = push && (count_q != CNT_FULL || pop);
    assign drop   = push && !accept;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            word_cnt_q  <= '0;
            prev_key_q  <= '0;
            seen_q      <= 1'b0;
            order_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push)
                fill_q <= '0;
            else if (bus.DINEN)
                fill_q <= fill_q + 1'b1;

            if (accept)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (accept)
                word_cnt_q <= word_cnt_q + 32'd1;
            if (drop)
                overflow_q <= 1'b1;

            if (bus.DINEN) begin
                if (seen_q && bus.DIN[KEYW-1:0] < prev_key_q)
                    order_err_q <= 1'b1;
                prev_key_q <= bus.DIN[KEYW-1:0];
                seen_q     <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < NREC; k++) begin
            if (bus.DINEN && P_LOG'(k) == fill_q)
                asm_q[k*DATW +: DATW] <= bus.DIN;
        end
        if (accept)
            mem[wr_ptr_q] <= word_next;
    end

    assign bus.DOT       = mem[rd_ptr_q];
    assign bus.DOTEN     = (count_q != '0);
    assign bus.IN_FULL   = (count_q >= CNT_HIGH);
    assign bus.WORD_CNT  = word_cnt_q;
    assign bus.ORDER_ERR = order_err_q;
    assign bus.OVERFLOW  = overflow_q;
endmodule

// File: tb/tb_sorted_record_packer.sv
// Self-checking bench for sorted_record_packer: directed scenarios plus a
// randomized stream, compared each cycle against a queue-based model.
module tb_sorted_record_packer;
    localparam int P_LOG = 3;
    localparam int DATW  = 64;
    localparam int NREC  = 8;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    sorted_record_packer_if #(.P_LOG(P_LOG), .DATW(DATW)) bus ();

    sorted_record_packer #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(32), .FIFO_LOG(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [63:0]  pend[$];
    logic [511:0] wq[$];
    logic [31:0]  m_wc;
    bit           m_oerr, m_ovf, m_seen;
    logic [31:0]  m_prev;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rec(input logic [31:0] key);
        return {32'hFFFF_FFFF, key};
    endfunction

    task automatic model_reset();
        pend.delete();
        wq.delete();
        m_wc   = 0;
        m_oerr = 0;
        m_ovf  = 0;
        m_seen = 0;
        m_prev = 0;
    endtask

    task automatic model_step(input logic [63:0] din, input bit en, input bit fl, input bit dq);
        int           size0;
        bit           pop_ok, do_push;
        logic [511:0] w;
        size0  = wq.size();
        pop_ok = dq && size0 > 0;
        if (en) begin
            if (m_seen && din[31:0] < m_prev) m_oerr = 1;
            m_prev = din[31:0];
            m_seen = 1;
            pend.push_back(din);
        end
        do_push = (pend.size() == NREC) || (fl && pend.size() > 0);
        w = '1;
        if (do_push) begin
            for (int j = 0; j < pend.size(); j++) w[j*64 +: 64] = pend[j];
            pend.delete();
        end
        if (pop_ok) void'(wq.pop_front());
        if (do_push) begin
            if (size0 == DEPTH && !pop_ok) m_ovf = 1;
            else begin
                wq.push_back(w);
                m_wc = m_wc + 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("doten", 512'(bus.DOTEN), 512'(wq.size() > 0));
        if (wq.size() > 0) chk("dot", bus.DOT, wq[0]);
        chk("in_full", 512'(bus.IN_FULL), 512'(wq.size() >= DEPTH - 1));
        chk("word_cnt", 512'(bus.WORD_CNT), 512'(m_wc));
        chk("order_err", 512'(bus.ORDER_ERR), 512'(m_oerr));
        chk("overflow", 512'(bus.OVERFLOW), 512'(m_ovf));
    endtask

    task automatic cycle(input logic [63:0] din, input bit en, input bit fl, input bit dq);
        bus.DIN     = din;
        bus.DINEN   = en;
        bus.FLUSH   = fl;
        bus.OUT_DEQ = dq;
        @(posedge CLK);
        model_step(din, en, fl, dq);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        bus.DINEN   = 1'b0;
        bus.FLUSH   = 1'b0;
        bus.OUT_DEQ = 1'b0;
        @(posedge CLK);
        model_reset();
        #1;
        chk("rst_doten", 512'(bus.DOTEN), 512'(0));
        check_outputs();
        RST = 1'b0;
    endtask

    task automatic feed(input logic [31:0] k0, input int n, input bit dq);
        for (int i = 0; i < n; i++) cycle(rec(k0 + 32'(i)), 1, 0, dq);
    endtask

    initial begin
        logic [31:0] key;
        bus.DIN     = '0;
        bus.DINEN   = 1'b0;
        bus.FLUSH   = 1'b0;
        bus.OUT_DEQ = 1'b0;
        do_reset();

        // full stream: keys 1..16 with the consumer always popping
        for (int i = 0; i < 16; i++) begin
            cycle(rec(32'(i + 1)), 1, 0, 1);
            if (i == 7) begin
                chk("fs_doten", 512'(bus.DOTEN), 512'(1));
                chk("fs_w0_s0", 512'(bus.DOT[63:0]), 512'(64'hFFFF_FFFF_0000_0001));
                chk("fs_w0_s7", 512'(bus.DOT[479:448]), 512'(8));
            end
        end
        chk("fs_w1_s0", 512'(bus.DOT[31:0]), 512'(9));
        chk("fs_wc", 512'(bus.WORD_CNT), 512'(2));
        for (int i = 0; i < 3; i++) cycle('0, 0, 0, 1);

        // flush of a partial word, idle flush, flush with a record
        feed(32'd20, 3, 0);
        cycle('0, 0, 1, 0);
        chk("fl_s2", 512'(bus.DOT[159:128]), 512'(22));
        chk("fl_pad", 512'(bus.DOT[511:192]), {192'd0, {320{1'b1}}});
        cycle('0, 0, 1, 0);
        chk("fl_idle_wc", 512'(bus.WORD_CNT), 512'(3));
        feed(32'd30, 3, 1);
        cycle(rec(32'd33), 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle('0, 0, 0, 1);

        // backpressure, full with simultaneous pop, then a dropped word
        do_reset();
        feed(32'd100, 24, 0);
        chk("bp_in_full", 512'(bus.IN_FULL), 512'(1));
        feed(32'd124, 8, 0);
        chk("bp_ovf0", 512'(bus.OVERFLOW), 512'(0));
        feed(32'd132, 7, 0);
        cycle(rec(32'd139), 1, 0, 1);
        chk("fp_ovf0", 512'(bus.OVERFLOW), 512'(0));
        chk("fp_wc", 512'(bus.WORD_CNT), 512'(5));
        feed(32'd140, 8, 0);
        chk("bp_ovf1", 512'(bus.OVERFLOW), 512'(1));
        chk("bp_wc", 512'(bus.WORD_CNT), 512'(5));
        for (int i = 0; i < 5; i++) cycle('0, 0, 0, 1);
        chk("bp_empty", 512'(bus.DOTEN), 512'(0));

        // order checker
        do_reset();
        cycle(rec(32'd5), 1, 0, 0);
        cycle(rec(32'd5), 1, 0, 0);
        chk("ord_eq", 512'(bus.ORDER_ERR), 512'(0));
        cycle(rec(32'd4), 1, 0, 0);
        chk("ord_dec", 512'(bus.ORDER_ERR), 512'(1));
        cycle(rec(32'd6), 1, 0, 0);
        chk("ord_sticky", 512'(bus.ORDER_ERR), 512'(1));

        // reset mid-word
        do_reset();
        feed(32'd1, 5, 0);
        do_reset();
        feed(32'd100, 8, 0);
        chk("rm_s0", 512'(bus.DOT[31:0]), 512'(100));
        chk("rm_wc", 512'(bus.WORD_CNT), 512'(1));

        // randomized stream
        do_reset();
        key = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] d;
            bit en, fl, dq;
            en = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 19) == 0);
            dq = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 49) == 0) key = $urandom();
            else key = key + 32'($urandom_range(0, 2));
            d = {32'($urandom()), key};
            cycle(d, en, fl, dq);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
